// File: rtl/dcache_to_mem_converter.sv
// dcache_to_mem_converter
//   Bridges a CVA6 dcache request port (this block responds) to the MEM bus
//   (this block initiates). Only one transaction is in flight at a time.
//   Loads use the two-phase index/tag handshake. Stores present the full
//   address in the request cycle.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req_port_i/_o     dcache request / response structs
//   m_mem_*           MEM bus initiator (req/gnt, valid, addr, r/wdata, we, be, error)
//   err_o             one-cycle pulse: errored response or timeout
//   busy_o            FSM not in IDLE
//
// Optional feature
//   DCACHE_MEM_CONV_TIMEOUT_EN: when defined, ISSUE/WAIT_RESP are bounded
//   by TimeoutCycles. On expiry the FSM returns to IDLE, err_o pulses, and a
//   load is answered with zero data.

package dcache_to_mem_converter_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_TAG_WIDTH;
    int unsigned DcacheIdWidth;
  } cva6_cfg_t;

  localparam int unsigned DefXlen   = 64;
  localparam int unsigned DefIdxW   = 12;
  localparam int unsigned DefTagW   = 44;
  localparam int unsigned DefIdW    = 2;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:               DefXlen,
    DCACHE_INDEX_WIDTH: DefIdxW,
    DCACHE_TAG_WIDTH:   DefTagW,
    DcacheIdWidth:      DefIdW
  };

  typedef struct packed {
    logic [DefIdxW-1:0]   address_index;
    logic [DefTagW-1:0]   address_tag;
    logic [DefXlen-1:0]   data_wdata;
    logic                 data_req;
    logic                 data_we;
    logic [DefXlen/8-1:0] data_be;
    logic [DefIdW-1:0]    data_id;
    logic                 kill_req;
    logic                 tag_valid;
  } default_dcache_req_i_t;

  typedef struct packed {
    logic                 data_gnt;
    logic                 data_rvalid;
    logic [DefIdW-1:0]    data_rid;
    logic [DefXlen-1:0]   data_rdata;
  } default_dcache_req_o_t;

endpackage

module dcache_to_mem_converter #(
  parameter dcache_to_mem_converter_pkg::cva6_cfg_t CVA6Cfg =
    dcache_to_mem_converter_pkg::cva6_cfg_empty,
  parameter type dcache_req_i_t = dcache_to_mem_converter_pkg::default_dcache_req_i_t,
  parameter type dcache_req_o_t = dcache_to_mem_converter_pkg::default_dcache_req_o_t,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  dcache_req_i_t               req_port_i,
  output dcache_req_o_t               req_port_o,
  output logic                        m_mem_req,
  input  logic                        m_mem_gnt,
  input  logic                        m_mem_valid,
  output logic [CVA6Cfg.XLEN-1:0]     m_mem_addr,
  input  logic [CVA6Cfg.XLEN-1:0]     m_mem_rdata,
  output logic [CVA6Cfg.XLEN-1:0]     m_mem_wdata,
  output logic                        m_mem_we,
  output logic [CVA6Cfg.XLEN/8-1:0]   m_mem_be,
  input  logic                        m_mem_error,
  output logic                        err_o,
  output logic                        busy_o
);

  localparam int unsigned XLEN  = CVA6Cfg.XLEN;
  localparam int unsigned IDX_W = CVA6Cfg.DCACHE_INDEX_WIDTH;
  localparam int unsigned TAG_W = CVA6Cfg.DCACHE_TAG_WIDTH;
  localparam int unsigned ID_W  = CVA6Cfg.DcacheIdWidth;
  localparam int unsigned BE_W  = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TAG  = 2'd1,
    ISSUE     = 2'd2,
    WAIT_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              gnt;
  logic              timeout;
  logic [XLEN-1:0]   addr_full;

`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TimeoutCycles + 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign timeout = ((state_q == ISSUE) || (state_q == WAIT_RESP)) &&
                   (cnt_q == CNT_W'(TimeoutCycles));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles == 0);
  assign timeout = 1'b0;
`endif

  // Zero-extend or truncate {tag,index} to XLEN; doubleword aligned, byte
  // position is carried by be alone.
  assign addr_full = XLEN'({tag_q, idx_q});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    id_d     = id_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    gnt      = 1'b0;
    m_mem_req = 1'b0;
    err_o    = 1'b0;
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        // IDLE is re-entered in the rvalid cycle; holding off the grant there
        // keeps gnt and rvalid mutually exclusive.
        gnt = req_port_i.data_req & ~rvalid_q;
        if (gnt) begin
          idx_d   = req_port_i.address_index;
          we_d    = req_port_i.data_we;
          be_d    = req_port_i.data_be;
          wdata_d = req_port_i.data_wdata;
          id_d    = req_port_i.data_id;
          if (req_port_i.data_we) begin
            tag_d   = req_port_i.address_tag;
            state_d = ISSUE;
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d = WAIT_TAG;
          end
        end
      end

      WAIT_TAG: begin
        if (req_port_i.kill_req) begin
          state_d = IDLE;
        end else if (req_port_i.tag_valid) begin
          tag_d   = req_port_i.address_tag;
          state_d = ISSUE;
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ISSUE: begin
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Request is withdrawn in the expiry cycle so a coincident grant
        // cannot start an access the FSM no longer tracks.
        if (!timeout) begin
          m_mem_req = 1'b1;
          if (m_mem_gnt) state_d = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (!timeout && m_mem_valid) begin
          state_d  = IDLE;
          err_o    = m_mem_error;
          rvalid_d = ~we_q;
          if (!we_q) rdata_d = m_mem_rdata;
        end
      end

      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d  = IDLE;
      err_o    = 1'b1;
      rvalid_d = ~we_q;
      if (!we_q) rdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      id_q     <= id_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef DCACHE_MEM_CONV_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign m_mem_addr  = addr_full & ~XLEN'(7);
  assign m_mem_wdata = wdata_q;
  assign m_mem_we    = we_q;
  assign m_mem_be    = be_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    req_port_o             = '0;
    req_port_o.data_gnt    = gnt;
    req_port_o.data_rvalid = rvalid_q;
    req_port_o.data_rid    = id_q;
    req_port_o.data_rdata  = rdata_q;
  end

endmodule
